modulo_unit: RTL and testbench

Parametrised iterative modulo/divide unit. It replaces the repeated-subtraction modulo datapath with a self-sequenced shift-subtract (restoring) engine of configurable width. The engine supports unsigned and signed operands, detects division by zero, and uses a start/busy/valid handshake. It sits between the top-level control and the result register file, and delivers quotient and remainder in a fixed WIDTH+2 cycles.

---
 rtl/modulo_pkg.sv | 21 ++
 rtl/modulo_step.sv | 24 ++
 rtl/modulo_unit.sv | 167 ++++++++++++++++
 tb/tb_modulo_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/modulo_pkg.sv
// Shared types and constants for the iterative shift-subtract divide/modulo unit.
package modulo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam int MAX_WIDTH = 64;

  // Quotient reported for a zero divisor; sliced down to the operand width.
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/modulo_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor if it fits.
// Purely combinational; no handshake.
module modulo_step
  import modulo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   p_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH:0]   p_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;

  // A set top bit of p would push the shifted value past 2^(WIDTH+1), which always exceeds the divisor.
  always_comb begin
    shifted = {p_i[WIDTH-1:0], bit_i};
    q_o     = p_i[WIDTH] | (shifted >= {1'b0, dsr_i});
    p_o     = q_o ? (shifted - {1'b0, dsr_i}) : shifted;
  end

endmodule

// File: rtl/modulo_unit.sv
// Iterative signed/unsigned divide/modulo with start/busy/valid handshake.
// Result valid WIDTH+2 edges after start (divide by zero: 2 edges); start while busy is ignored.
module modulo_unit
  import modulo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div0_o
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   p_q, p_d;
  logic             sgn_q, sgn_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_flag_q, div0_flag_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div0_q, div0_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   p_nxt;
  logic             q_bit;

  modulo_step #(.WIDTH(WIDTH)) u_step (
    .p_i   (p_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dsr_i (dsr_q),
    .p_o   (p_nxt),
    .q_o   (q_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    p_d         = p_q;
    sgn_d       = sgn_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div0_flag_d = div0_flag_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div0_d      = div0_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE also accepts a start so a held start_i costs no extra idle cycle.
        if (start_i) begin
          dvd_d   = dividend_i;
          dsr_d   = divisor_i;
          sgn_d   = signed_i;
          state_d = PREP;
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        if (dsr_q == '0) begin
          div0_flag_d = 1'b1;
          state_d     = FIX;
        end else begin
          div0_flag_d = 1'b0;
          dvd_d       = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
          dsr_d       = (sgn_q && dsr_q[WIDTH-1]) ? -dsr_q : dsr_q;
          neg_quo_d   = sgn_q & (dvd_q[WIDTH-1] ^ dsr_q[WIDTH-1]);
          neg_rem_d   = sgn_q & dvd_q[WIDTH-1];
          p_d         = '0;
          cnt_d       = CW'(WIDTH - 1);
          state_d     = CALC;
        end
      end
      CALC: begin
        // Quotient bits enter at the bottom as dividend bits leave at the top.
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        p_d   = p_nxt;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        state_d = DONE;
        if (div0_flag_q) begin
          quotient_d  = DIV0_QUOT[WIDTH-1:0];
          remainder_d = dvd_q;
          div0_d      = 1'b1;
        end else begin
          quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
          remainder_d = (neg_rem_q && (p_q[WIDTH-1:0] != '0)) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
          div0_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_i && (state_q != IDLE)) begin
      state_d     = IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div0_d      = div0_q;
    end

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      p_q         <= '0;
      sgn_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_flag_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      p_q         <= p_d;
      sgn_q       <= sgn_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      div0_flag_q <= div0_flag_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div0_q      <= div0_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div0_o      = div0_q;

endmodule

// File: tb/tb_modulo_unit.sv
// Directed bench for modulo_unit at WIDTH=16 with hand-computed quotients, remainders and edge timing.
module tb_modulo_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        signed_i;
  logic [15:0] dividend_i;
  logic [15:0] divisor_i;
  logic        abort_i;
  logic        busy_o;
  logic        valid_o;
  logic [15:0] quotient_o;
  logic [15:0] remainder_o;
  logic        div0_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  modulo_unit #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div0_o      (div0_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Called just after a posedge; the following posedge is E0.
  task automatic go(input logic sg, input logic [15:0] a, input logic [15:0] b);
    signed_i   = sg;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i    = 1'b0;
  endtask

  // Returns the edge index (relative to the last edge seen) at which valid_o first rose, -1 on timeout.
  task automatic wait_valid(output int edge_n);
    edge_n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (valid_o) begin
        edge_n = i;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic sg, input logic [15:0] a, input logic [15:0] b,
                           input int exp_edge, input logic [15:0] exp_q, input logic [15:0] exp_r,
                           input logic exp_d0);
    int e;
    go(sg, a, b);
    wait_valid(e);
    chk({tag, "_edge"}, e, exp_edge);
    chk({tag, "_busy"}, busy_o, 1'b1);
    chk({tag, "_quo"}, quotient_o, exp_q);
    chk({tag, "_rem"}, remainder_o, exp_r);
    chk({tag, "_div0"}, div0_o, exp_d0);
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, valid_o, 1'b0);
    chk({tag, "_idle"}, busy_o, 1'b0);
  endtask

  initial begin
    int e;
    int nv;
    rst_i      = 1'b0;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    abort_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_quo", quotient_o, 16'h0);
    chk("rst_rem", remainder_o, 16'h0);
    chk("rst_div0", div0_o, 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;

    run_check("u100_7", 1'b0, 16'd100, 16'd7, 18, 16'd14, 16'd2, 1'b0);
    run_check("sm100_7", 1'b1, 16'hFF9C, 16'd7, 18, 16'hFFF2, 16'hFFFE, 1'b0);
    run_check("s100_m7", 1'b1, 16'd100, 16'hFFF9, 18, 16'hFFF2, 16'h0002, 1'b0);
    run_check("div0", 1'b0, 16'h1234, 16'h0, 2, 16'hFFFF, 16'h1234, 1'b1);
    run_check("u9_4", 1'b0, 16'd9, 16'd4, 18, 16'd2, 16'd1, 1'b0);
    run_check("smin_m1", 1'b1, 16'h8000, 16'hFFFF, 18, 16'h8000, 16'h0, 1'b0);
    run_check("uffff", 1'b0, 16'hFFFF, 16'hFFFF, 18, 16'd1, 16'd0, 1'b0);

    // Second start sampled at E5 must be ignored.
    go(1'b0, 16'd7, 16'd3);
    e  = -1;
    nv = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin
        dividend_i = 16'd50;
        divisor_i  = 16'd5;
        start_i    = 1'b1;
      end
      if (i == 5) start_i = 1'b0;
      if (valid_o) begin
        nv++;
        if (e < 0) e = i;
      end
    end
    chk("ign_edge", e, 18);
    chk("ign_count", nv, 1);
    chk("ign_quo", quotient_o, 16'd2);
    chk("ign_rem", remainder_o, 16'd1);

    // Held start: second operands latched at E19, second valid at E37.
    signed_i   = 1'b0;
    dividend_i = 16'd100;
    divisor_i  = 16'd7;
    start_i    = 1'b1;
    @(posedge clk); #1;
    dividend_i = 16'd200;
    wait_valid(e);
    chk("hold1_edge", e, 18);
    chk("hold1_quo", quotient_o, 16'd14);
    chk("hold1_rem", remainder_o, 16'd2);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("hold_rearm", busy_o, 1'b1);
    wait_valid(e);
    chk("hold2_edge", e + 19, 37);
    chk("hold2_quo", quotient_o, 16'd28);
    chk("hold2_rem", remainder_o, 16'd4);
    @(posedge clk); #1;

    // Reset asserted at E8 mid-operation.
    go(1'b0, 16'd100, 16'd7);
    repeat (7) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_valid", valid_o, 1'b0);
    chk("mrst_quo", quotient_o, 16'h0);
    chk("mrst_rem", remainder_o, 16'h0);
    chk("mrst_div0", div0_o, 1'b0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (valid_o) nv++;
    end
    chk("mrst_novalid", nv, 0);

    // Abort sampled at E9: previous results retained, engine immediately reusable.
    run_check("pre_abort", 1'b0, 16'd100, 16'd7, 18, 16'd14, 16'd2, 1'b0);
    go(1'b0, 16'd9, 16'd4);
    repeat (8) @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_valid", valid_o, 1'b0);
    chk("abort_quo", quotient_o, 16'd14);
    chk("abort_rem", remainder_o, 16'd2);
    run_check("post_abort", 1'b0, 16'd50, 16'd6, 18, 16'd8, 16'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
